// File: rtl/control_seq.sv
// Microcoded control sequencer for the Hmmm CPU.
// One micro-step per clock; all outputs are registered on the falling edge so the
// datapath sees stable strobes at the following rising edge.
module control_seq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] bus,
  input  logic [15:0]       ir_data,
  input  logic              mem_ready,
  input  logic              in_valid,
  input  logic              out_ready,
  input  logic              tmp0_zero,
  input  logic              tmp0_neg,
  output logic              mar_in,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              pc_out,
  output logic              pc_jump,
  output logic              pc_increment,
  output logic              tmp0_in,
  output logic              tmp1_in,
  output logic              alu_out,
  output logic [2:0]        alu_op,
  output logic [3:0]        reg_sel,
  output logic              reg_in,
  output logic              reg_out,
  output logic              ir_in,
  output logic              in_out,
  output logic              out_in,
  output logic              halt,
  output logic              illegal_op,
  output logic              retire
);

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluMul = 3'b010;

  typedef enum logic [0:0] {StRun, StHalted} state_e;
  typedef enum logic [2:0] {StepT0, StepT1, StepT2, StepT3, StepT4} step_e;

  typedef struct packed {
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic pc_out;
    logic pc_jump;
    logic pc_increment;
    logic tmp0_in;
    logic tmp1_in;
    logic alu_out;
    logic reg_in;
    logic reg_out;
    logic ir_in;
    logic in_out;
    logic out_in;
  } strobe_t;

  state_e              state_q, state_d;
  step_e               step_q, step_d;
  strobe_t             strb_q, strb_d, strb_s;
  logic                bus_en_q, bus_en_d, drv_en;
  logic [DATA_W-1:0]   bus_q, bus_d, drv_val;
  logic [3:0]          reg_sel_q, reg_sel_d, sel_val;
  logic                sel_we;
  logic [2:0]          alu_op_q, alu_op_d;
  logic                halt_q, halt_d;
  logic                illegal_q, illegal_d;
  logic                retire_q, retire_d;
  logic                need_mem, need_in, need_out, stall;
  logic                last, go_halt, go_illegal, taken;

  logic [3:0]          op, rx, ry, rz;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   sext, zext, addr_imm;

  assign op  = ir_data[15:12];
  assign rx  = ir_data[11:8];
  assign ry  = ir_data[7:4];
  assign rz  = ir_data[3:0];
  assign imm = ir_data[7:0];

  // Immediate forms: data immediates span DATA_W, address immediates are cut to ADDR_W.
  always_comb begin
    sext = {{(DATA_W-8){imm[7]}}, imm};
    zext = {{(DATA_W-8){1'b0}}, imm};
    addr_imm = '0;
    addr_imm[ADDR_W-1:0] = imm[ADDR_W-1:0];
  end

  // Branch condition for the 11xx family, evaluated on tmp0 flags at T3.
  always_comb begin
    unique case (op[1:0])
      2'b00:   taken = tmp0_zero;
      2'b01:   taken = ~tmp0_zero;
      2'b10:   taken = ~tmp0_zero & ~tmp0_neg;
      default: taken = tmp0_neg;
    endcase
  end

  // Micro-step decode: strobes wanted by the current step plus its handshake needs.
  always_comb begin
    strb_s     = '0;
    drv_en     = 1'b0;
    drv_val    = '0;
    sel_we     = 1'b0;
    sel_val    = reg_sel_q;
    alu_op_d   = alu_op_q;
    need_mem   = 1'b0;
    need_in    = 1'b0;
    need_out   = 1'b0;
    last       = 1'b0;
    go_halt    = 1'b0;
    go_illegal = 1'b0;
    if (state_q == StRun) begin
      if (step_q == StepT0) begin
        strb_s.pc_out = 1'b1;
        strb_s.mar_in = 1'b1;
      end else if (step_q == StepT1) begin
        strb_s.mdr_out      = 1'b1;
        strb_s.ir_in        = 1'b1;
        strb_s.pc_increment = 1'b1;
        need_mem            = 1'b1;
      end else begin
        case (op)
          4'h0: begin
            last   = 1'b1;
            sel_we = (ir_data[1:0] != 2'b00);
            sel_val = rx;
            unique case (ir_data[1:0])
              2'b00: go_halt = 1'b1;
              2'b01: begin
                strb_s.in_out = 1'b1;
                strb_s.reg_in = 1'b1;
                need_in       = 1'b1;
              end
              2'b10: begin
                strb_s.out_in  = 1'b1;
                strb_s.reg_out = 1'b1;
                need_out       = 1'b1;
              end
              default: begin
                strb_s.reg_out = 1'b1;
                strb_s.pc_jump = 1'b1;
              end
            endcase
          end
          4'h1: begin
            drv_en        = 1'b1;
            drv_val       = sext;
            strb_s.reg_in = 1'b1;
            sel_we        = 1'b1;
            sel_val       = rx;
            last          = 1'b1;
          end
          4'h2, 4'h3, 4'h4: begin
            if (step_q == StepT2) begin
              strb_s.mar_in = 1'b1;
              if (op == 4'h4) begin
                strb_s.reg_out = 1'b1;
                sel_we         = 1'b1;
                sel_val        = ry;
              end else begin
                drv_en  = 1'b1;
                drv_val = addr_imm;
              end
            end else begin
              need_mem = 1'b1;
              sel_we   = 1'b1;
              sel_val  = rx;
              last     = 1'b1;
              // Store when opcode is storen, or loadr/storer with ir[0] set.
              if (op == 4'h3 || (op == 4'h4 && ir_data[0])) begin
                strb_s.reg_out = 1'b1;
                strb_s.mdr_in  = 1'b1;
              end else begin
                strb_s.mdr_out = 1'b1;
                strb_s.reg_in  = 1'b1;
              end
            end
          end
          4'h5, 4'h6, 4'h7, 4'h8: begin
            if (op == 4'h8 && !MUL_EN) begin
              go_illegal = 1'b1;
              last       = 1'b1;
            end else if (step_q == StepT2) begin
              strb_s.reg_out = 1'b1;
              strb_s.tmp0_in = 1'b1;
              sel_we         = 1'b1;
              sel_val        = (op == 4'h5) ? rx : ry;
            end else if (step_q == StepT3) begin
              strb_s.tmp1_in = 1'b1;
              if (op == 4'h5) begin
                drv_en  = 1'b1;
                drv_val = sext;
              end else begin
                strb_s.reg_out = 1'b1;
                sel_we         = 1'b1;
                sel_val        = rz;
              end
            end else begin
              strb_s.alu_out = 1'b1;
              strb_s.reg_in  = 1'b1;
              sel_we         = 1'b1;
              sel_val        = rx;
              last           = 1'b1;
              unique case (op)
                4'h7:    alu_op_d = AluSub;
                4'h8:    alu_op_d = AluMul;
                default: alu_op_d = AluAdd;
              endcase
            end
          end
          4'hB: begin
            if (rx == 4'd0 || step_q == StepT3) begin
              drv_en         = 1'b1;
              drv_val        = addr_imm;
              strb_s.pc_jump = 1'b1;
              last           = 1'b1;
            end else begin
              // calln: link register captures the already-incremented PC.
              strb_s.pc_out = 1'b1;
              strb_s.reg_in = 1'b1;
              sel_we        = 1'b1;
              sel_val       = rx;
            end
          end
          4'hC, 4'hD, 4'hE, 4'hF: begin
            if (step_q == StepT2) begin
              strb_s.reg_out = 1'b1;
              strb_s.tmp0_in = 1'b1;
              sel_we         = 1'b1;
              sel_val        = rx;
            end else begin
              last = 1'b1;
              if (taken) begin
                drv_en         = 1'b1;
                drv_val        = addr_imm;
                strb_s.pc_jump = 1'b1;
              end
            end
          end
          default: begin
            go_illegal = 1'b1;
            last       = 1'b1;
          end
        endcase
      end
    end
  end

  assign stall = (need_mem & ~mem_ready) | (need_in & ~in_valid) | (need_out & ~out_ready);

  // Next-state: a stalled step emits nothing and repeats; halt/illegal retire on entry.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    strb_d    = '0;
    bus_en_d  = 1'b0;
    bus_d     = '0;
    reg_sel_d = reg_sel_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    retire_d  = 1'b0;
    if (state_q == StRun && !stall) begin
      if (go_halt || go_illegal) begin
        state_d   = StHalted;
        step_d    = StepT0;
        halt_d    = 1'b1;
        illegal_d = illegal_q | go_illegal;
        retire_d  = 1'b1;
      end else begin
        strb_d   = strb_s;
        bus_en_d = drv_en;
        bus_d    = drv_val;
        if (sel_we) begin
          reg_sel_d = sel_val;
        end
        if (last) begin
          step_d   = StepT0;
          retire_d = 1'b1;
        end else begin
          step_d = step_e'(step_q + 3'd1);
        end
      end
    end
  end

  // Falling-edge output and sequence registers; reset aborts any step in flight.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      step_q    <= StepT0;
      strb_q    <= '0;
      bus_en_q  <= 1'b0;
      bus_q     <= '0;
      reg_sel_q <= '0;
      alu_op_q  <= AluAdd;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      strb_q    <= strb_d;
      bus_en_q  <= bus_en_d;
      bus_q     <= bus_d;
      reg_sel_q <= reg_sel_d;
      alu_op_q  <= (state_q == StRun) ? alu_op_d : alu_op_q;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
    end
  end

  assign bus          = bus_en_q ? bus_q : {DATA_W{1'bz}};
  assign mar_in       = strb_q.mar_in;
  assign mdr_in       = strb_q.mdr_in;
  assign mdr_out      = strb_q.mdr_out;
  assign pc_out       = strb_q.pc_out;
  assign pc_jump      = strb_q.pc_jump;
  assign pc_increment = strb_q.pc_increment;
  assign tmp0_in      = strb_q.tmp0_in;
  assign tmp1_in      = strb_q.tmp1_in;
  assign alu_out      = strb_q.alu_out;
  assign reg_in       = strb_q.reg_in;
  assign reg_out      = strb_q.reg_out;
  assign ir_in        = strb_q.ir_in;
  assign in_out       = strb_q.in_out;
  assign out_in       = strb_q.out_in;
  assign alu_op       = alu_op_q;
  assign reg_sel      = reg_sel_q;
  assign halt         = halt_q;
  assign illegal_op   = illegal_q;
  assign retire       = retire_q;

endmodule
